mcp49xx_spi_multi: RTL and testbench
====================================

Name: mcp49xx_spi_multi

Overview:
- Parametrised driver for N parallel MCP4801/4811/4821 (8/10/12-bit) single-channel SPI DACs.
- All DACs share SCLK, CS_n and LDAC_n; each DAC has its own SDI line.
- Replaces the fixed 3×10-bit, SCLK=clk driver with:
  - a programmable SCLK divider,
  - a valid/ready handshake,
  - a done pulse.
- Sits between the vector/audio sample logic and the external DAC pins.

Parameters:
- NCH, 3: number of DACs driven in parallel (≥1).
- DW, 10: DAC resolution; legal values are 8, 10 and 12 only. Any other value is an elaboration error.
- CLK_DIV, 2: sys clocks per SCLK half-period (≥1). SCLK frequency = f_clk / (2·CLK_DIV).
- LDAC_W, 2: sys clocks LDAC_n is held low (≥1).

Ports:
- I_clk  in  1  system clock; all logic on rising edge
- I_reset_n  in  1  asynchronous active-low reset
- I_data  in  NCH*DW  channel k occupies bits [k*DW+DW-1 : k*DW]
- I_header  in  4  config nibble {A/B=0, don't care, GA_n, SHDN_n}, common to all channels
- I_valid  in  1  sample offer
- O_ready  out  1  block can accept a sample
- O_done  out  1  one-cycle pulse when LDAC_n deasserts
- O_sclk  out  1  SPI clock, idle low (mode 0,0)
- O_cs_n  out  1  shared chip select
- O_ldac_n  out  1  shared latch strobe
- O_sd  out  NCH  per-DAC serial data, MSB first

Behaviour:
- Reset values (asynchronous, I_reset_n=0): O_cs_n=1, O_ldac_n=1, O_sclk=0, O_sd=0, O_ready=1, O_done=0. State goes to S_IDLE and all counters to 0.
- Reset mid-frame aborts immediately. Pins return to idle levels in the same instant and no LDAC pulse is issued.
- Frame per channel: 16 bits = {I_header, data[DW-1:0], (12-DW) zero bits}. Bit 15 goes out first.
- Accept: I_valid & O_ready at a rising edge. I_data and I_header are latched on that edge. When I_valid=0, nothing happens.
- State S_IDLE: O_ready=1.
  - On accept → S_SHIFT.
  - At the same edge: O_cs_n←0, O_sd←bit 15 of each channel, bit counter←0, half-period counter←0. O_ready←0.
- State S_SHIFT: half-period counter counts 0..CLK_DIV-1. At the terminal count O_sclk toggles.
  - 0→1 (rising SCLK): the DAC samples. O_sd is unchanged.
  - 1→0 (falling SCLK): if fewer than 16 falling edges have occurred, O_sd←next bit.
  - On the 16th falling edge → S_CSHI with O_cs_n←1. O_sd←0, O_sclk stays 0.
  - Result: exactly 16 SCLK rising edges per frame. O_sd is stable ≥CLK_DIV clocks either side of each rising edge.
- State S_CSHI: wait CLK_DIV clocks (meets T_LD), then → S_LDAC with O_ldac_n←0.
- State S_LDAC: hold O_ldac_n=0 for LDAC_W clocks, then O_ldac_n←1, O_done←1 for one cycle, → S_IDLE, O_ready←1.
- Latency: from the accept edge to O_ready high is 33·CLK_DIV + LDAC_W clocks. With defaults this is 68 clocks.
- I_data/I_header changes while busy have no effect on the frame in progress.
- O_cs_n, O_ldac_n, O_sclk and O_sd are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro MCP49XX_PREFETCH_EN.
- Defined: a one-entry pending buffer is added.
  - O_ready = !pending_valid in every state, so one sample can be accepted while a frame is in flight.
  - At LDAC end, if pending_valid: O_done pulses, the block goes straight to S_SHIFT with the pending sample (no S_IDLE cycle), and pending_valid clears.
  - Back-to-back frame period is exactly 33·CLK_DIV + LDAC_W clocks.
  - An accept in S_IDLE with the buffer empty starts the frame directly, as in the base behaviour.
- Undefined: no pending buffer; behaviour is exactly as in the Behaviour section.

Test Plan:
- Single frame, defaults: I_header=4'b0011, ch0=10'h3FF, ch1=10'h000, ch2=10'h2AA.
  - Expect O_sd[0]=16'h3FFC, O_sd[1]=16'h3000, O_sd[2]=16'h3AA8, sampled on the 16 SCLK rising edges.
  - Expect exactly 16 rising edges, O_cs_n low throughout them, and O_ready back high 68 clocks after the accept.
- DW=12, NCH=1, CLK_DIV=1, LDAC_W=1, data 12'hABC, header 4'b0001: expect serial 16'h1ABC, SCLK = clk/2, ready 34 clocks after accept.
- LDAC timing: expect O_ldac_n low exactly LDAC_W clocks, starting CLK_DIV clocks after O_cs_n rises. O_done pulses once, coincident with O_ldac_n returning high.
- Reset asserted at the 7th SCLK rising edge: all outputs are at reset values immediately, with no LDAC pulse. A new accept after release produces a complete, correct frame.
- Handshake:
  - I_valid held high continuously without the macro: frames are separated by one S_IDLE cycle (period 69 clocks with defaults).
  - With MCP49XX_PREFETCH_EN: period 68 clocks, with a second sample accepted mid-frame.
  - With MCP49XX_PREFETCH_EN and a third offer while the buffer is full: O_ready=0 and the third sample is not latched.
- Data stability: toggle I_data every clock during a frame and check the serial output equals the value latched at accept.

Source files
------------

// File: rtl/mcp49xx_spi_multi.sv
// Driver for NCH parallel MCP4801/4811/4821 DACs with shared SCLK, CS_n and LDAC_n, and one SDI line per DAC.
// Define MCP49XX_PREFETCH_EN to add a one-entry pending buffer so that frames can run back-to-back.

module mcp49xx_spi_multi #(
  parameter int NCH     = 3,
  parameter int DW      = 10,
  parameter int CLK_DIV = 2,
  parameter int LDAC_W  = 2
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic [NCH*DW-1:0] I_data,
  input  logic [3:0]        I_header,
  input  logic              I_valid,
  output logic              O_ready,
  output logic              O_done,
  output logic              O_sclk,
  output logic              O_cs_n,
  output logic              O_ldac_n,
  output logic [NCH-1:0]    O_sd
);

  generate
    if (DW != 8 && DW != 10 && DW != 12) begin : g_bad_dw
      $error("mcp49xx_spi_multi: DW must be 8, 10 or 12");
    end
    if (NCH < 1 || CLK_DIV < 1 || LDAC_W < 1) begin : g_bad_param
      $error("mcp49xx_spi_multi: NCH, CLK_DIV and LDAC_W must be at least 1");
    end
  endgenerate

  localparam int CMAX = (CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CSHI,
    S_LDAC
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      bit_cnt, bit_nx;
  logic            sclk_nx, cs_nx, ldac_nx, done_nx;
  logic [NCH-1:0]  sd_nx;
  logic [15:0]     shreg [NCH];
  logic [15:0]     shreg_nx [NCH];

  logic              accept;
  logic              load;
  logic [NCH*DW-1:0] load_data;
  logic [3:0]        load_header;

  // The 16-bit word is the header nibble, then the sample, then zero padding up to 12 data bits.
  function automatic logic [15:0] make_frame(input logic [3:0] hdr, input logic [DW-1:0] d);
    logic [11:0] w;
    w = 12'(d) << (12 - DW);
    return {hdr, w};
  endfunction

`ifdef MCP49XX_PREFETCH_EN
  logic              pend_valid, pend_valid_nx;
  logic [NCH*DW-1:0] pend_data, pend_data_nx;
  logic [3:0]        pend_header, pend_header_nx;

  assign O_ready = !pend_valid;
`else
  assign O_ready = (state == S_IDLE);
`endif

  assign accept = I_valid & O_ready;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_nx      = bit_cnt;
    sclk_nx     = O_sclk;
    cs_nx       = O_cs_n;
    ldac_nx     = O_ldac_n;
    done_nx     = 1'b0;
    sd_nx       = O_sd;
    shreg_nx    = shreg;
    load        = 1'b0;
    load_data   = I_data;
    load_header = I_header;
`ifdef MCP49XX_PREFETCH_EN
    pend_valid_nx  = pend_valid;
    pend_data_nx   = pend_data;
    pend_header_nx = pend_header;
`endif

    case (state)
      S_IDLE: begin
`ifdef MCP49XX_PREFETCH_EN
        if (pend_valid) begin
          load          = 1'b1;
          load_data     = pend_data;
          load_header   = pend_header;
          pend_valid_nx = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end
`else
        if (accept) begin
          load = 1'b1;
        end
`endif
      end

      // Data changes only on the falling SCLK edge, so it is stable for CLK_DIV clocks around each rising edge.
      S_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          if (!O_sclk) begin
            sclk_nx = 1'b1;
          end else begin
            sclk_nx = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_nx = S_CSHI;
              cs_nx    = 1'b1;
              sd_nx    = '0;
              bit_nx   = '0;
            end else begin
              bit_nx = bit_cnt + 1'b1;
              for (int k = 0; k < NCH; k++) begin
                sd_nx[k]    = shreg[k][14];
                shreg_nx[k] = shreg[k] << 1;
              end
            end
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_CSHI: begin
        if (cnt == DIV_LAST) begin
          cnt_nx   = '0;
          state_nx = S_LDAC;
          ldac_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_LDAC: begin
        if (cnt == LDAC_LAST) begin
          cnt_nx   = '0;
          ldac_nx  = 1'b1;
          done_nx  = 1'b1;
          state_nx = S_IDLE;
`ifdef MCP49XX_PREFETCH_EN
          if (pend_valid) begin
            load          = 1'b1;
            load_data     = pend_data;
            load_header   = pend_header;
            pend_valid_nx = 1'b0;
          end
`endif
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: state_nx = S_IDLE;
    endcase

`ifdef MCP49XX_PREFETCH_EN
    // Outside S_IDLE an accepted sample waits in the pending slot until the current frame has been latched.
    if (accept && state != S_IDLE) begin
      pend_valid_nx  = 1'b1;
      pend_data_nx   = I_data;
      pend_header_nx = I_header;
    end
`endif

    if (load) begin
      state_nx = S_SHIFT;
      cs_nx    = 1'b0;
      sclk_nx  = 1'b0;
      cnt_nx   = '0;
      bit_nx   = '0;
      for (int k = 0; k < NCH; k++) begin
        shreg_nx[k] = make_frame(load_header, load_data[k*DW +: DW]);
        sd_nx[k]    = shreg_nx[k][15];
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      O_sclk   <= 1'b0;
      O_cs_n   <= 1'b1;
      O_ldac_n <= 1'b1;
      O_done   <= 1'b0;
      O_sd     <= '0;
      for (int k = 0; k < NCH; k++) begin
        shreg[k] <= '0;
      end
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_cnt  <= bit_nx;
      O_sclk   <= sclk_nx;
      O_cs_n   <= cs_nx;
      O_ldac_n <= ldac_nx;
      O_done   <= done_nx;
      O_sd     <= sd_nx;
      for (int k = 0; k < NCH; k++) begin
        shreg[k] <= shreg_nx[k];
      end
    end
  end

`ifdef MCP49XX_PREFETCH_EN
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_header <= '0;
    end else begin
      pend_valid  <= pend_valid_nx;
      pend_data   <= pend_data_nx;
      pend_header <= pend_header_nx;
    end
  end
`endif

endmodule

// File: tb/tb_mcp49xx_spi_multi.sv
// Self-checking bench for mcp49xx_spi_multi: table vectors, random samples and timing corner cases.
// Serial words are rebuilt from the pins and compared with the header/data/padding word layout.

module tb_mcp49xx_spi_multi;

  localparam int NCH        = 3;
  localparam int DW         = 10;
  localparam int CLK_DIV    = 2;
  localparam int LDAC_W     = 2;
  localparam int FRAME_CLKS = 33 * CLK_DIV + LDAC_W;
`ifdef MCP49XX_PREFETCH_EN
  localparam int STREAM_PERIOD = FRAME_CLKS;
`else
  localparam int STREAM_PERIOD = FRAME_CLKS + 1;
`endif

  typedef logic [NCH*DW-1:0] data_t;
  typedef logic [NCH*16-1:0] words_t;

  typedef struct {
    logic [3:0] hdr;
    data_t      data;
    words_t     exp;
    bit         scramble;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_n;
  data_t          data;
  logic [3:0]     hdr;
  logic           valid;
  logic           ready, done, sclk, cs_n, ldac_n;
  logic [NCH-1:0] sd;

  logic [11:0]    data2;
  logic [3:0]     hdr2;
  logic           valid2;
  logic           ready2, done2, sclk2, cs2_n, ldac2_n;
  logic [0:0]     sd2;

  always #5 clk = ~clk;

  mcp49xx_spi_multi #(.NCH(NCH), .DW(DW), .CLK_DIV(CLK_DIV), .LDAC_W(LDAC_W)) dut (
    .I_clk(clk), .I_reset_n(reset_n), .I_data(data), .I_header(hdr), .I_valid(valid),
    .O_ready(ready), .O_done(done), .O_sclk(sclk), .O_cs_n(cs_n), .O_ldac_n(ldac_n), .O_sd(sd)
  );

  mcp49xx_spi_multi #(.NCH(1), .DW(12), .CLK_DIV(1), .LDAC_W(1)) dut2 (
    .I_clk(clk), .I_reset_n(reset_n), .I_data(data2), .I_header(hdr2), .I_valid(valid2),
    .O_ready(ready2), .O_done(done2), .O_sclk(sclk2), .O_cs_n(cs2_n), .O_ldac_n(ldac2_n), .O_sd(sd2)
  );

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  words_t frame_q[$];
  int     csfall_q[$];
  words_t mon_words = '0;
  int     mon_bits = 0;
  logic   mon_prev_sclk = 1'b0;
  logic   mon_prev_cs = 1'b1;
  vec_t   vecs[8];

  // Rebuild what each DAC would shift in on SCLK rising edges; one queue entry per completed 16-bit frame.
  always @(negedge clk) begin
    cyc++;
    if (mon_prev_cs && !cs_n) begin
      csfall_q.push_back(cyc);
      mon_bits  = 0;
      mon_words = '0;
    end
    if (!mon_prev_sclk && sclk) begin
      for (int k = 0; k < NCH; k++) begin
        mon_words[k*16 +: 16] = {mon_words[k*16 +: 15], sd[k]};
      end
      mon_bits++;
      if (mon_bits == 16) frame_q.push_back(mon_words);
    end
    mon_prev_sclk = sclk;
    mon_prev_cs   = cs_n;
  end

  function automatic logic [15:0] model_word(input logic [3:0] h, input int unsigned d, input int dw);
    return 16'(int'(h) * 4096 + d * (1 << (12 - dw)));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int c, rises, ldac_low, done_c, cs_rise_c, ldac_fall_c, busy_ready, cs_bad, expired;
    logic psclk, pcs, pldac, done_ok, ready_at_done;
    words_t got;
    frame_q.delete();
    @(negedge clk);
    hdr = v.hdr; data = v.data; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    rises = 0; ldac_low = 0; done_c = -1; cs_rise_c = -1; ldac_fall_c = -1;
    busy_ready = 0; cs_bad = 0; expired = 1; done_ok = 1'b0; ready_at_done = 1'b0;
    psclk = 1'b0; pcs = 1'b0; pldac = 1'b1;
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      if (v.scramble) begin
        data = data_t'({$urandom, $urandom});
        hdr  = 4'($urandom);
      end
      if (!psclk && sclk) begin
        rises++;
        if (cs_n) cs_bad++;
      end
      if (!pcs && cs_n && cs_rise_c < 0) cs_rise_c = c;
      if (!ldac_n) begin
        ldac_low++;
        if (ldac_fall_c < 0) ldac_fall_c = c;
      end
      if (done) begin
        done_c = c;
        done_ok = (!pldac && ldac_n);
        ready_at_done = ready;
        expired = 0;
        break;
      end
      if (ready) busy_ready++;
      psclk = sclk; pcs = cs_n; pldac = ldac_n;
    end
    @(negedge clk);
    checkOutput({tag, "_timeout"}, 64'(expired), 64'd0);
    checkOutput({tag, "_done_single"}, 64'(done), 64'd0);
    checkOutput({tag, "_rises"}, 64'(rises), 64'd16);
    checkOutput({tag, "_cs_low_at_rise"}, 64'(cs_bad), 64'd0);
    checkOutput({tag, "_latency"}, 64'(done_c), 64'(FRAME_CLKS));
    checkOutput({tag, "_ldac_width"}, 64'(ldac_low), 64'(LDAC_W));
    checkOutput({tag, "_ldac_delay"}, 64'(ldac_fall_c - cs_rise_c), 64'(CLK_DIV));
    checkOutput({tag, "_done_with_ldac"}, 64'(done_ok), 64'd1);
    checkOutput({tag, "_ready_at_done"}, 64'(ready_at_done), 64'd1);
`ifdef MCP49XX_PREFETCH_EN
    checkOutput({tag, "_ready_busy"}, 64'(busy_ready), 64'(done_c));
`else
    checkOutput({tag, "_ready_busy"}, 64'(busy_ready), 64'd0);
`endif
    checkOutput({tag, "_frames"}, 64'(frame_q.size()), 64'd1);
    if (frame_q.size() > 0) begin
      got = frame_q.pop_front();
      for (int k = 0; k < NCH; k++) begin
        checkOutput($sformatf("%s_ch%0d", tag, k), 64'(got[k*16 +: 16]), 64'(v.exp[k*16 +: 16]));
      end
    end
  endtask

  task automatic resetAbortTest();
    int rises, expired, ldac_seen, done_seen;
    logic psclk;
    frame_q.delete();
    @(negedge clk);
    hdr = vecs[0].hdr; data = vecs[0].data; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    rises = 0; expired = 1; psclk = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!psclk && sclk) rises++;
      psclk = sclk;
      if (rises == 7) begin
        expired = 0;
        break;
      end
    end
    checkOutput("abort_reach_7th_rise", 64'(expired), 64'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", 64'(cs_n), 64'd1);
    checkOutput("abort_ldac_n", 64'(ldac_n), 64'd1);
    checkOutput("abort_sclk", 64'(sclk), 64'd0);
    checkOutput("abort_sd", 64'(sd), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd1);
    checkOutput("abort_done", 64'(done), 64'd0);
    ldac_seen = 0; done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (!ldac_n) ldac_seen++;
    end
    reset_n = 1'b1;
    repeat (FRAME_CLKS + 10) begin
      @(negedge clk);
      if (!ldac_n) ldac_seen++;
      if (done) done_seen++;
    end
    checkOutput("abort_no_ldac", 64'(ldac_seen), 64'd0);
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    checkOutput("abort_no_frame", 64'(frame_q.size()), 64'd0);
    applyStimulus(vecs[0], "post_reset");
  endtask

  task automatic streamTest();
    int expired;
    frame_q.delete();
    csfall_q.delete();
    @(negedge clk);
    hdr = vecs[2].hdr; data = vecs[2].data; valid = 1'b1;
    expired = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (csfall_q.size() >= 3) begin
        expired = 0;
        break;
      end
    end
    valid = 1'b0;
    repeat (FRAME_CLKS + 5) @(negedge clk);
    checkOutput("stream_timeout", 64'(expired), 64'd0);
    if (csfall_q.size() >= 3) begin
      checkOutput("stream_period1", 64'(csfall_q[1] - csfall_q[0]), 64'(STREAM_PERIOD));
      checkOutput("stream_period2", 64'(csfall_q[2] - csfall_q[1]), 64'(STREAM_PERIOD));
    end
    checkOutput("stream_frames", 64'(frame_q.size()), 64'd3);
    while (frame_q.size() > 0) begin
      checkOutput("stream_word", 64'(frame_q.pop_front()), 64'(vecs[2].exp));
    end
  endtask

`ifdef MCP49XX_PREFETCH_EN
  task automatic prefetchFullTest();
    int expired;
    frame_q.delete();
    @(negedge clk);
    hdr = vecs[3].hdr; data = vecs[3].data; valid = 1'b1;
    @(negedge clk);
    hdr = vecs[4].hdr; data = vecs[4].data;
    @(negedge clk);
    checkOutput("prefetch_full_ready", 64'(ready), 64'd0);
    hdr = vecs[5].hdr; data = vecs[5].data;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    expired = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (frame_q.size() >= 2) begin
        expired = 0;
        break;
      end
    end
    repeat (FRAME_CLKS + 5) @(negedge clk);
    checkOutput("prefetch_timeout", 64'(expired), 64'd0);
    checkOutput("prefetch_frames", 64'(frame_q.size()), 64'd2);
    if (frame_q.size() >= 2) begin
      checkOutput("prefetch_first", 64'(frame_q[0]), 64'(vecs[3].exp));
      checkOutput("prefetch_second", 64'(frame_q[1]), 64'(vecs[4].exp));
    end
  endtask
`endif

  task automatic wideDacTest();
    int c, rises, first_c, last_c, expired;
    logic ps;
    logic [15:0] word;
    @(negedge clk);
    data2 = 12'hABC; hdr2 = 4'b0001; valid2 = 1'b1;
    @(posedge clk);
    #1 valid2 = 1'b0;
    rises = 0; first_c = -1; last_c = -1; expired = 1; ps = 1'b0; word = '0;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!ps && sclk2) begin
        rises++;
        word = {word[14:0], sd2[0]};
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      ps = sclk2;
      if (ready2) begin
        expired = 0;
        break;
      end
    end
    checkOutput("dw12_timeout", 64'(expired), 64'd0);
    checkOutput("dw12_latency", 64'(c), 64'd34);
    checkOutput("dw12_word", 64'(word), 64'(model_word(4'b0001, 32'h0ABC, 12)));
    checkOutput("dw12_rises", 64'(rises), 64'd16);
    checkOutput("dw12_first_rise", 64'(first_c), 64'd1);
    checkOutput("dw12_rise_span", 64'(last_c - first_c), 64'd30);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; hdr = '0; data = '0;
    valid2 = 1'b0; hdr2 = '0; data2 = '0;

    vecs[0] = '{4'b0011, {10'h2AA, 10'h000, 10'h3FF}, {16'h3AA8, 16'h3000, 16'h3FFC}, 1'b0};
    vecs[1] = '{4'b0001, {10'h001, 10'h200, 10'h155}, {16'h1004, 16'h1800, 16'h1554}, 1'b1};
    for (int i = 2; i < 8; i++) begin
      vecs[i].hdr      = 4'($urandom);
      vecs[i].data     = data_t'({$urandom, $urandom});
      vecs[i].scramble = (i % 2) == 1;
      for (int k = 0; k < NCH; k++) begin
        vecs[i].exp[k*16 +: 16] = model_word(vecs[i].hdr, 32'(vecs[i].data[k*DW +: DW]), DW);
      end
    end

    repeat (2) @(negedge clk);
    checkOutput("reset_cs_n", 64'(cs_n), 64'd1);
    checkOutput("reset_ldac_n", 64'(ldac_n), 64'd1);
    checkOutput("reset_sclk", 64'(sclk), 64'd0);
    checkOutput("reset_sd", 64'(sd), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end
    resetAbortTest();
    streamTest();
`ifdef MCP49XX_PREFETCH_EN
    prefetchFullTest();
`endif
    wideDacTest();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
